// File: rtl/manch_pkg.sv
// Shared types for the Manchester frame decoder: FSM state encoding and pair polarity constants.
package manch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    DONE   = 2'd2
  } state_e;

  localparam int POL_IEEE   = 0;
  localparam int POL_THOMAS = 1;

endpackage

// File: rtl/manch_pair_dec.sv
// Combinational decode of one Manchester pair; flags the non-transition codes "00"/"11".
module manch_pair_dec (
  input  logic [1:0] pair_i,
  input  logic       pol_i,
  output logic       bit_o,
  output logic       invalid_o
);

  assign bit_o     = pair_i[1] ^ pol_i;
  assign invalid_o = ~(pair_i[1] ^ pair_i[0]);

endmodule

// File: rtl/manch_decoder.sv
// Frame-level Manchester decoder: latches a frame on start, decodes one pair per cycle.
// Optional MANCH_ERR_EN: invalid pairs decode to 0 and raise a sticky err with first index.
module manch_decoder
  import manch_pkg::*;
#(
  parameter int MAX_SYMS = 7,
  parameter int POL      = POL_IEEE,
  localparam int SIZE_W  = $clog2(MAX_SYMS+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2*MAX_SYMS-1:0] rstring,
  input  logic [SIZE_W-1:0]     size,
  output logic [MAX_SYMS-1:0]   dstring,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [SIZE_W-1:0]     err_idx
);

  localparam logic [SIZE_W-1:0] MAX_L = SIZE_W'(MAX_SYMS);

  state_e                state_q, state_d;
  logic [SIZE_W-1:0]     cnt_q, cnt_d, len_q, len_d, size_clamp;
  logic [2*MAX_SYMS-1:0] shadow_q, shadow_d;
  logic [MAX_SYMS-1:0]   dstring_q, dstring_d, bit_w, inv_w;
  logic                  sel_bit, dec_bit;

  // One decoder per pair position, all fed from the shadow copy only.
  for (genvar i = 0; i < MAX_SYMS; i++) begin : g_pair
    manch_pair_dec u_pair (
      .pair_i   (shadow_q[2*i +: 2]),
      .pol_i    (1'(POL)),
      .bit_o    (bit_w[i]),
      .invalid_o(inv_w[i])
    );
  end

  assign size_clamp = (size > MAX_L) ? MAX_L : size;

`ifdef MANCH_ERR_EN
  logic              err_q, err_d, sel_inv;
  logic [SIZE_W-1:0] err_idx_q, err_idx_d;

  always_comb begin
    sel_inv = 1'b0;
    for (int i = 0; i < MAX_SYMS; i++)
      if (cnt_q == SIZE_W'(i)) sel_inv = inv_w[i];
  end

  assign dec_bit = sel_bit & ~sel_inv;
  assign err     = err_q;
  assign err_idx = err_idx_q;
`else
  logic unused_inv;
  assign unused_inv = ^inv_w;
  assign dec_bit    = sel_bit;
  assign err        = 1'b0;
  assign err_idx    = '0;
`endif

  always_comb begin
    sel_bit = 1'b0;
    for (int i = 0; i < MAX_SYMS; i++)
      if (cnt_q == SIZE_W'(i)) sel_bit = bit_w[i];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    shadow_d  = shadow_q;
    dstring_d = dstring_q;
`ifdef MANCH_ERR_EN
    err_d     = err_q;
    err_idx_d = err_idx_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          shadow_d  = rstring;
          len_d     = size_clamp;
          cnt_d     = '0;
          dstring_d = '0;
`ifdef MANCH_ERR_EN
          err_d     = 1'b0;
          err_idx_d = '0;
`endif
          state_d   = (size_clamp == '0) ? DONE : DECODE;
        end
      end
      DECODE: begin
        for (int i = 0; i < MAX_SYMS; i++)
          if (cnt_q == SIZE_W'(i)) dstring_d[i] = dec_bit;
`ifdef MANCH_ERR_EN
        if (sel_inv && !err_q) begin
          err_d     = 1'b1;
          err_idx_d = cnt_q;
        end
`endif
        cnt_d = cnt_q + SIZE_W'(1);
        if (cnt_q == len_q - SIZE_W'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      shadow_q  <= '0;
      dstring_q <= '0;
`ifdef MANCH_ERR_EN
      err_q     <= 1'b0;
      err_idx_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      shadow_q  <= shadow_d;
      dstring_q <= dstring_d;
`ifdef MANCH_ERR_EN
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
`endif
    end
  end

  assign dstring = dstring_q;
  assign busy    = (state_q == DECODE);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_manch_decoder.sv
// Directed bench: default, POL=1 and MAX_SYMS=4 instances share one stimulus stream.
module tb_manch_decoder;
  import manch_pkg::*;

  logic        clk, rst, start;
  logic [13:0] rstring;
  logic [2:0]  size;
  logic [7:0]  rstring4;

  logic [6:0] dstring0, dstring1;
  logic [3:0] dstring4;
  logic       busy0, done0, err0, busy1, done1, err1, busy4, done4, err4;
  logic [2:0] err_idx0, err_idx1, err_idx4;

  int errs, checks;
  int de0, de1, de4, bc0, bc4;

  assign rstring4 = rstring[7:0];

  manch_decoder u_dut (
    .clk(clk), .rst(rst), .start(start), .rstring(rstring), .size(size),
    .dstring(dstring0), .busy(busy0), .done(done0), .err(err0), .err_idx(err_idx0)
  );

  manch_decoder #(.POL(POL_THOMAS)) u_dut_pol (
    .clk(clk), .rst(rst), .start(start), .rstring(rstring), .size(size),
    .dstring(dstring1), .busy(busy1), .done(done1), .err(err1), .err_idx(err_idx1)
  );

  manch_decoder #(.MAX_SYMS(4)) u_dut_m4 (
    .clk(clk), .rst(rst), .start(start), .rstring(rstring4), .size(size),
    .dstring(dstring4), .busy(busy4), .done(done4), .err(err4), .err_idx(err_idx4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called just after an edge ("edge 0"); records first done edge per instance.
  task automatic run_frame(input logic [13:0] rs, input logic [2:0] sz);
    start = 1'b1; rstring = rs; size = sz;
    de0 = -1; de1 = -1; de4 = -1; bc0 = 0; bc4 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (done0 && de0 < 0) de0 = k;
      if (done1 && de1 < 0) de1 = k;
      if (done4 && de4 < 0) de4 = k;
      bc0 += int'(busy0);
      bc4 += int'(busy4);
    end
  endtask

  initial begin
    int cnt_done, cnt_busy;
    errs = 0; checks = 0;
    rst = 1'b1; start = 1'b0; rstring = '0; size = '0;
    #12;
    chk("rst_dstring", 32'(dstring0), 32'h0);
    chk("rst_busy",    32'(busy0),    32'h0);
    chk("rst_done",    32'(done0),    32'h0);
    chk("rst_err",     32'(err0),     32'h0);
    chk("rst_err_idx", 32'(err_idx0), 32'h0);
    @(posedge clk); #1; rst = 1'b0;
    tick();

    // pairs 01,10,01
    run_frame(14'b00000000011001, 3'd3);
    chk("f1_done_edge", 32'(de0), 32'd4);
    chk("f1_busy_cyc",  32'(bc0), 32'd3);
    chk("f1_dstring",   32'(dstring0), 32'b0000010);
    chk("f1_pol1",      32'(dstring1), 32'b0000101);
    chk("f1_m4",        32'(dstring4), 32'b0010);
    chk("f1_m4_edge",   32'(de4), 32'd4);

    // Restart from DONE with a full 7-pair frame.
    run_frame(14'b10101010101010, 3'd7);
    chk("f2_done_edge", 32'(de0), 32'd8);
    chk("f2_busy_cyc",  32'(bc0), 32'd7);
    chk("f2_dstring",   32'(dstring0), 32'h7f);
    chk("f2_pol1",      32'(dstring1), 32'h0);
    chk("f2_pol1_edge", 32'(de1), 32'd8);
    chk("f2_m4_edge",   32'(de4), 32'd5);
    chk("f2_m4_busy",   32'(bc4), 32'd4);
    chk("f2_m4",        32'(dstring4), 32'hf);

    run_frame(14'b10101010101010, 3'd0);
    chk("f3_done_edge", 32'(de0), 32'd1);
    chk("f3_busy_cyc",  32'(bc0), 32'd0);
    chk("f3_dstring",   32'(dstring0), 32'h0);
    chk("f3_m4_edge",   32'(de4), 32'd1);

    // pairs 01,11,00
    run_frame(14'b00000000001101, 3'd3);
    chk("f4_done_edge", 32'(de0), 32'd4);
`ifdef MANCH_ERR_EN
    chk("f4_err",     32'(err0),     32'd1);
    chk("f4_err_idx", 32'(err_idx0), 32'd1);
    chk("f4_dstring", 32'(dstring0), 32'b000);
`else
    chk("f4_err",     32'(err0),     32'd0);
    chk("f4_err_idx", 32'(err_idx0), 32'd0);
    chk("f4_dstring", 32'(dstring0), 32'b010);
`endif

    // Mid-frame input changes and a start re-pulse must not disturb the frame.
    start = 1'b1; rstring = 14'b00000000011001; size = 3'd3;
    de0 = -1; bc0 = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (k == 2) begin rstring = 14'b10101010101010; size = 3'd7; start = 1'b1; end
      if (k == 3) start = 1'b0;
      if (done0 && de0 < 0) de0 = k;
      bc0 += int'(busy0);
    end
    chk("f5_done_edge", 32'(de0), 32'd4);
    chk("f5_busy_cyc",  32'(bc0), 32'd3);
    chk("f5_dstring",   32'(dstring0), 32'b0000010);
    chk("f5_err_clr",   32'(err0), 32'd0);

    // Reset during cycle 2 of a 5-pair frame.
    start = 1'b1; rstring = 14'b10101010101010; size = 3'd5;
    tick();
    start = 1'b0;
    tick();
    chk("f6_busy_mid", 32'(busy0), 32'd1);
    chk("f6_d0_mid",   32'(dstring0), 32'd1);
    rst = 1'b1;
    #1;
    chk("f6_rst_dstring", 32'(dstring0), 32'h0);
    chk("f6_rst_busy",    32'(busy0),    32'h0);
    chk("f6_rst_done",    32'(done0),    32'h0);
    chk("f6_rst_err",     32'(err0),     32'h0);
    tick();
    rst = 1'b0;
    cnt_done = 0; cnt_busy = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      cnt_done += int'(done0);
      cnt_busy += int'(busy0);
    end
    chk("f6_no_done", 32'(cnt_done), 32'd0);
    chk("f6_no_busy", 32'(cnt_busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
